// File: rtl/onehot_sel_decoder.sv
// Registered binary-to-one-hot select decoder with range checking and a sweep mode.
// Sweep mode walks the one-hot output from a start index up to OUT_W-1, one index per cycle.
module onehot_sel_decoder #(
   parameter int SEL_W = 4,
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic [SEL_W-1:0] select,
   input  logic             abort,
   output logic [OUT_W-1:0] en_out,
   output logic             out_valid,
   output logic             sel_err,
   output logic             busy
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   // One extra bit keeps the OUT_W == 2**SEL_W comparison from wrapping.
   localparam logic [SEL_W:0] OUT_W_X = (SEL_W+1)'(OUT_W);
   localparam logic [SEL_W:0] LAST_X  = (SEL_W+1)'(OUT_W - 1);

   state_t           state_r, state_s;
   logic [SEL_W-1:0] idx_r, idx_s;
   logic [OUT_W-1:0] en_s;
   logic             valid_s;
   logic             err_s;
   logic [SEL_W:0]   sel_ext_s;
   logic [SEL_W:0]   nxt_s;

   function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W:0] i);
      logic [OUT_W-1:0] oh;
      oh = '0;
      for (int b = 0; b < OUT_W; b++) begin
         oh[b] = (i == (SEL_W+1)'(b));
      end
      return oh;
   endfunction

   assign sel_ext_s = {1'b0, select};
   assign nxt_s     = {1'b0, idx_r} + {{SEL_W{1'b0}}, 1'b1};
   assign in_ready  = (state_r == IDLE);
   assign busy      = (state_r == SWEEP);

   // Next-state, index and next-output decode.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      en_s    = '0;
      valid_s = 1'b0;
      err_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               if (sel_ext_s >= OUT_W_X) begin
                  err_s = 1'b1;
               end else begin
                  en_s    = onehot(sel_ext_s);
                  valid_s = 1'b1;
                  if (mode) begin
                     idx_s = select;
                     // A sweep starting on the last index is a single-bit sweep.
                     if (sel_ext_s == LAST_X) begin
                        state_s = IDLE;
                     end else begin
                        state_s = SWEEP;
                     end
                  end else begin
                     state_s = IDLE;
                  end
               end
            end else begin
               state_s = IDLE;
            end
         end
         SWEEP: begin
            // Abort wins even on the edge that would present the final bit.
            if (abort) begin
               state_s = IDLE;
            end else begin
               idx_s   = nxt_s[SEL_W-1:0];
               en_s    = onehot(nxt_s);
               valid_s = 1'b1;
               if (nxt_s == LAST_X) begin
                  state_s = IDLE;
               end else begin
                  state_s = SWEEP;
               end
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, index and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         idx_r     <= '0;
         en_out    <= '0;
         out_valid <= 1'b0;
         sel_err   <= 1'b0;
      end else begin
         state_r   <= state_s;
         idx_r     <= idx_s;
         en_out    <= en_s;
         out_valid <= valid_s;
         sel_err   <= err_s;
      end
   end

endmodule

// File: doc/onehot_sel_decoder.md
# onehot_sel_decoder

Registered, parametrised binary-to-one-hot select decoder for the single-cycle processor's register-file and peripheral write-enable paths. It generalises the fixed 4-to-16 decoder in three ways:
- select width and output count are parameters;
- out-of-range selects are flagged rather than silently ignored;
- a sweep mode walks the one-hot output across a range of indices, one per cycle, for register-file initialisation and clearing.

Requests use a valid/ready handshake. The output is registered with one-cycle latency.

## Interface

Parameters:
- SEL_W, 4: select width in bits; range 1–8.
- OUT_W, 16: number of one-hot outputs; range 2..2**SEL_W. Indices ≥ OUT_W are out of range.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request; combinational, equal to (state == IDLE).
- mode  in  1  0 = single decode, 1 = sweep; sampled with the request.
- select  in  SEL_W  decode index (single mode) or start index (sweep mode).
- abort  in  1  terminates an active sweep; ignored in IDLE.
- en_out  out  OUT_W  registered one-hot enable, or all zero.
- out_valid  out  1  en_out carries a valid one-hot this cycle.
- sel_err  out  1  one-cycle pulse: an accepted request had select ≥ OUT_W.
- busy  out  1  sweep in progress (state == SWEEP).

## Operation

- State machine has two states: IDLE and SWEEP. It also holds an index register idx of SEL_W bits.
- Reset (rst_n = 0 at an edge) sets:
  - state = IDLE, idx = 0;
  - en_out = 0, out_valid = 0, sel_err = 0.
- Reset applies regardless of state, including mid-sweep. Because busy = 0 and in_ready = 1 derive from state, they hold these values out of reset.
- A request is accepted at an edge where in_valid && in_ready.
- IDLE, no request accepted:
  - en_out <= 0, out_valid <= 0, sel_err <= 0.
- IDLE, request accepted, select ≥ OUT_W (either mode):
  - en_out <= 0, out_valid <= 0, sel_err <= 1;
  - state stays IDLE.
- IDLE, accepted with mode = 0:
  - en_out <= 1 << select, out_valid <= 1;
  - state stays IDLE.
- IDLE, accepted with mode = 1:
  - en_out <= 1 << select, out_valid <= 1, idx <= select;
  - state <= SWEEP, unless select == OUT_W−1, in which case state stays IDLE (single-bit sweep).
- SWEEP, abort = 1:
  - en_out <= 0, out_valid <= 0, state <= IDLE;
  - idx is left unchanged.
- SWEEP, abort = 0:
  - idx <= idx+1, en_out <= 1 << (idx+1), out_valid <= 1;
  - if idx+1 == OUT_W−1, state <= IDLE.
- SWEEP ignores in_valid, because in_ready = 0.
- Abort on the edge that would present the final bit wins: en_out is zero and the final bit is never driven.
- en_out never has more than one bit set. en_out == 0 whenever out_valid == 0.
- Index arithmetic is SEL_W+1 bits wide, so the OUT_W == 2**SEL_W comparison cannot wrap.

## Timing

- Latency is 1 cycle: a request accepted at edge k appears on en_out/out_valid/sel_err after edge k.
- Single mode sustains one decode per cycle, back-to-back.
- A sweep from start s presents OUT_W−s consecutive valid cycles, after edges k … k+OUT_W−s−1.
- in_ready is 0 for the OUT_W−s−1 cycles after edge k. It returns to 1 during the cycle the final bit (OUT_W−1) is presented.
- A request accepted in that cycle shows its output on the very next cycle, with no bubble.
- sel_err is high for exactly one cycle per out-of-range request.

## Test plan

- **Reset:** hold rst_n = 0 for 2 edges with in_valid = 1.
  - Required: en_out = 0, out_valid = 0, sel_err = 0, busy = 0, in_ready = 1.
- **Single-decode sweep of selects** (defaults): select 0..15, mode = 0, in_valid every cycle.
  - Required: en_out = 0x0001, 0x0002 … 0x8000 on consecutive cycles, each one cycle after its request; out_valid continuously 1.
- **Out of range** (SEL_W = 4, OUT_W = 10): select = 12, mode = 0.
  - Required: sel_err = 1 for one cycle, en_out = 0, out_valid = 0.
  - Then select = 9: en_out = 0x200.
- **Full sweep** (defaults): mode = 1, select = 13.
  - Required: en_out = 0x2000, 0x4000, 0x8000 on 3 consecutive cycles, busy = 1 for the first 2.
  - A mode = 0, select = 2 request held during the sweep is accepted while 0x8000 is shown; the next cycle shows 0x0004.
- **Abort:** mode = 1, select = 0; assert abort during the cycle en_out = 0x0008.
  - Required: next cycle en_out = 0, out_valid = 0, busy = 0, in_ready = 1.
  - Also assert abort together with the cycle presenting 0x4000. Required: 0x8000 is never output.
- **Reset mid-sweep:** mode = 1, select = 0; drop rst_n while en_out = 0x0010.
  - Required: next cycle all outputs 0, busy = 0.
  - After release, a new single decode of select = 5 gives en_out = 0x0020.
